compound_writer_mc: RTL
=======================

// Module: compound_writer_mc
// PURPOSE
//  Multi-channel successor of the single-port compound-record writer.
//  - Blocking-reads an XW-bit increment on a_in and adds it to an internal accumulator.
//  - Blocking-writes a {mode, x, y} compound record to one of NCH output channels, in round-robin order.
//  - Both sides use the sync/notify handshake; a per-write timeout drops stalled transfers.
// PARAMETERS
//  XW       8   width of a_in, accumulator and record field x
//  NCH      4   number of output channels (2..16); channel index width is $clog2(NCH)
//  TIMEOUT  0   max cycles a write waits for sync; 0 = wait forever
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, asynchronous, active-high
//  a_in           in   XW      increment value
//  a_in_sync      in   1       producer has valid a_in this cycle
//  a_in_notify    out  1       block ready to read a_in
//  b_out_mode     out  NCH     per-channel mode bit (0=read, 1=write)
//  b_out_x        out  NCH*XW  per-channel x; channel k at [k*XW +: XW]
//  b_out_y        out  NCH     per-channel flag y
//  b_out_sync     in   NCH     per-channel consumer accept
//  b_out_notify   out  NCH     per-channel write request
//  drop_count     out  16      saturating count of timed-out writes
// BEHAVIOUR
//  Reset values (all registers):
//  - every channel record = {read, 0, 0}; b_out_notify=0; a_in_notify=1
//  - section=SEC_READ; ch=0; acc=0; mode=read; y=0; drop_count=0; wait_cnt=0
//  SEC_READ:
//  - a_in_notify=1; b_out_sync is ignored.
//  - On a_in_sync=1 in cycle N, at edge N+1:
//    - acc <= acc + a_in, mod 2^XW (carry discarded).
//    - Record of channel ch <= {mode, acc+a_in, y}.
//    - b_out_notify[ch] <= 1; a_in_notify <= 0; wait_cnt <= 0; section <= SEC_WRITE.
//  SEC_WRITE:
//  - Only channel ch has notify=1; a_in_sync is ignored.
//  - The record of ch is held stable. Other channels keep their last records.
//  - On b_out_sync[ch]=1 (transfer), at the next edge:
//    - notify[ch] <= 0; a_in_notify <= 1; section <= SEC_READ.
//    - ch <= (ch==NCH-1) ? 0 : ch+1; mode <= ~mode; y <= ~y.
//  - b_out_sync on channels other than ch is ignored.
//  - If TIMEOUT>0, wait_cnt increments each cycle without sync.
//    - When wait_cnt==TIMEOUT-1 with no sync, the write is dropped:
//      notify[ch] <= 0; drop_count++ (holds at 16'hFFFF); a_in_notify <= 1; section <= SEC_READ.
//    - ch still advances. mode and y do not toggle.
//  - Sync in the same cycle as expiry counts as a transfer (sync wins); no drop.
//  Latency:
//  - a_in accepted in cycle N -> b_out_notify high from cycle N+1.
//  - Write completes in cycle M -> a_in_notify high from cycle M+1.
//  - Minimum 2 cycles per record.
//  Other rules:
//  - Reset mid-write: notify drops immediately (asynchronously); the record is lost and not counted.
//  - At most one notify bit is high at any time (one-hot or zero).
// STRUCTURE
//  Shared package compound_writer_pkg:
//  - mode_e {MODE_READ=0, MODE_WRITE=1}
//  - sections_e {SEC_READ, SEC_WRITE}
//  - DROP_CW=16
//  Sub-module hs_timeout (load/enable/expire counter, TIMEOUT parameter, tied off when TIMEOUT=0).
//  Top level holds the FSM, accumulator, round-robin pointer and output record registers.
// TESTING
//  - Reset check: assert rst mid-SEC_WRITE -> notify all 0, a_in_notify=1, all x=0, drop_count=0.
//  - Round robin, NCH=4, XW=8: a_in=1,2,3,4,5, each write synced after 1 cycle
//    -> ch0 x=1 mode=0 y=0; ch1 x=3 mode=1 y=1; ch2 x=6; ch3 x=10; ch0 x=15 mode=0.
//  - Wrap: acc=250, a_in=10 -> x=4 (mod 256); ch=3 -> next ch=0.
//  - Stall: hold b_out_sync[ch]=0 for 20 cycles with TIMEOUT=0
//    -> record stable, notify stays 1, a_in_sync pulses ignored, no drop.
//  - Timeout, TIMEOUT=5, no sync -> notify falls after 5 cycles, drop_count=1, ch advances, y unchanged.
//    Sync on the 5th cycle -> transfer, drop_count stays 0.
//  - Wrong-channel sync: with ch=1 active, pulse b_out_sync[0] and b_out_sync[2] -> no completion.

Source files
------------

// File: rtl/compound_writer_pkg.sv
// compound_writer_pkg: shared types and constants for the compound-record writer
package compound_writer_pkg;
  typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_e;
  typedef enum logic {SEC_READ, SEC_WRITE} sections_e;
  localparam int DROP_CW = 16;
endpackage

// File: rtl/compound_writer_mc_if.sv
// compound_writer_mc_if: producer-side read channel and per-channel record outputs
interface compound_writer_mc_if
  import compound_writer_pkg::*;
#(
  parameter int XW  = 8,
  parameter int NCH = 4
);
  logic [XW-1:0]      a_in;
  logic               a_in_sync;
  logic               a_in_notify;
  logic [NCH-1:0]     b_out_mode;
  logic [NCH*XW-1:0]  b_out_x;
  logic [NCH-1:0]     b_out_y;
  logic [NCH-1:0]     b_out_sync;
  logic [NCH-1:0]     b_out_notify;
  logic [DROP_CW-1:0] drop_count;
  modport master (
    output a_in, a_in_sync, b_out_sync,
    input  a_in_notify, b_out_mode, b_out_x, b_out_y, b_out_notify, drop_count
  );
  modport slave (
    input  a_in, a_in_sync, b_out_sync,
    output a_in_notify, b_out_mode, b_out_x, b_out_y, b_out_notify, drop_count
  );
endinterface

// File: rtl/compound_writer_mc_hs_timeout.sv
// compound_writer_mc_hs_timeout: write-wait counter that flags expiry after TIMEOUT stalled cycles
module compound_writer_mc_hs_timeout #(
  parameter int TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  if (TIMEOUT == 0) begin : g_off
    logic unused_in;
    assign unused_in = ^{clk, rst, load_i, en_i};
    assign expire_o = 1'b0;
  end else begin : g_on
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] wait_cnt_q;
    assign expire_o = en_i && (wait_cnt_q == CW'(TIMEOUT - 1));
    // wait counter: cleared when a write starts, advances on each stalled cycle
    always_ff @(posedge clk or posedge rst)
      if (rst) wait_cnt_q <= '0;
      else if (load_i) wait_cnt_q <= '0;
      else if (en_i && !expire_o) wait_cnt_q <= wait_cnt_q + 1'b1;
  end
endmodule

// File: rtl/compound_writer_mc.sv
// compound_writer_mc: accumulates increments and writes {mode,x,y} records round-robin to NCH channels
module compound_writer_mc
  import compound_writer_pkg::*;
#(
  parameter int XW      = 8,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 0
) (
  input logic clk,
  input logic rst,
  compound_writer_mc_if.slave bus
);
  localparam int CHW = $clog2(NCH);
  sections_e          section_q, section_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [XW-1:0]      acc_q, acc_d;
  mode_e              mode_q, mode_d;
  logic               y_q, y_d;
  logic [DROP_CW-1:0] drop_q, drop_d;
  logic [XW-1:0]      x_q [NCH];
  logic [NCH-1:0]     rmode_q, ry_q;
  logic               accept, xfer, stall, expire;
  compound_writer_mc_hs_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .en_i    (stall),
    .expire_o(expire)
  );
  // next-state: accept in read section, complete on transfer or timeout in write section
  always_comb begin
    accept    = section_q == SEC_READ && bus.a_in_sync;
    xfer      = section_q == SEC_WRITE && bus.b_out_sync[ch_q];
    stall     = section_q == SEC_WRITE && !bus.b_out_sync[ch_q];
    acc_d     = accept ? acc_q + bus.a_in : acc_q;
    section_d = accept ? SEC_WRITE : (xfer || expire) ? SEC_READ : section_q;
    ch_d      = (xfer || expire) ? (ch_q == CHW'(NCH - 1) ? '0 : ch_q + 1'b1) : ch_q;
    mode_d    = xfer ? (mode_q == MODE_READ ? MODE_WRITE : MODE_READ) : mode_q;
    y_d       = xfer ? ~y_q : y_q;
    drop_d    = (expire && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  // control state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      section_q <= SEC_READ;
      ch_q      <= '0;
      acc_q     <= '0;
      mode_q    <= MODE_READ;
      y_q       <= 1'b0;
      drop_q    <= '0;
    end else begin
      section_q <= section_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      mode_q    <= mode_d;
      y_q       <= y_d;
      drop_q    <= drop_d;
    end
  // per-channel records: loaded only on accept, so they stay stable during the write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q     <= '{default: '0};
      rmode_q <= '0;
      ry_q    <= '0;
    end else if (accept) begin
      x_q[ch_q]     <= acc_d;
      rmode_q[ch_q] <= mode_q;
      ry_q[ch_q]    <= y_q;
    end
  for (genvar k = 0; k < NCH; k++) begin : g_x
    assign bus.b_out_x[k*XW +: XW] = x_q[k];
  end
  assign bus.b_out_mode   = rmode_q;
  assign bus.b_out_y      = ry_q;
  assign bus.b_out_notify = section_q == SEC_WRITE ? NCH'(1) << ch_q : '0;
  assign bus.a_in_notify  = section_q == SEC_READ;
  assign bus.drop_count   = drop_q;
endmodule
